// File: rtl/pc_fetch_unit.sv
// Fetch front end: owns the PC, drives instruction memory and
// buffers {pc, instr} pairs for decode behind a valid/ready handshake.
module pc_fetch_unit #(
    parameter int unsigned MEM_WORDS = 512,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output logic [31:0] pc,
    input  logic [31:0] rd,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] fetch_count
);

    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned PW = $clog2(DEPTH);

    localparam logic [AW-1:0] RST_PC  = AW'(RESET_PC);
    localparam logic [PW:0]   DEPTH_C = (PW + 1)'(DEPTH);

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [31:0]   instr;
    } fetch_entry_t;

    logic [AW-1:0] pc_q;
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [PW:0]   count_q;
    logic [31:0]   fcnt_q;
    fetch_entry_t  buf_q [DEPTH];

    logic         pop;
    logic         can_push;
    logic         push;
    fetch_entry_t head_e;

    assign pop      = out_valid & out_ready;
    assign can_push = fetch_en & ((count_q < DEPTH_C) | pop);
    assign push     = can_push & ~redirect_valid;

    assign head_e      = buf_q[head_q];
    assign pc          = 32'(pc_q);
    assign out_valid   = (count_q != '0);
    assign out_instr   = out_valid ? head_e.instr : 32'd0;
    assign out_pc      = out_valid ? 32'(head_e.pc) : 32'd0;
    assign fetch_count = fcnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RST_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            fcnt_q  <= '0;
        end else if (redirect_valid) begin
            // Upper target bits drop out: the PC wraps modulo MEM_WORDS
            pc_q    <= redirect_pc[AW-1:0];
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                pc_q   <= pc_q + AW'(1);
                tail_q <= tail_q + PW'(1);
                fcnt_q <= fcnt_q + 32'd1;
            end
            if (pop) begin
                head_q <= head_q + PW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + (PW + 1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (PW + 1)'(1);
            end
        end
    end

    // Entry storage needs no reset; out_* are gated by out_valid
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            buf_q[tail_q] <= '{pc: pc_q, instr: rd};
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a queue-based reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic [31:0] pc;
    logic [31:0] rd;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [512];

    pc_fetch_unit #(
        .MEM_WORDS(512),
        .DEPTH(2),
        .RESET_PC(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fetch_en(fetch_en),
        .pc(pc),
        .rd(rd),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc(out_pc),
        .fetch_count(fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb rd = mem[pc[8:0]];

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", n, a, e, $time);
        end
    endtask

    // Reference model: a queue of (pc, instr) pairs, capacity 2
    typedef struct {
        int unsigned p;
        logic [31:0] i;
    } ent_t;

    ent_t        q[$];
    int unsigned mpc = 0;
    logic [31:0] mcnt = 0;
    bit          mvalid = 0;

    always @(posedge clk) begin
        bit mpop;
        bit mpush;
        if (rst) begin
            q.delete();
            mpc = 0;
            mcnt = 0;
            mvalid = 1;
        end else if (redirect_valid) begin
            q.delete();
            mpc = redirect_pc % 512;
        end else begin
            mpop  = (q.size() > 0) && out_ready;
            mpush = fetch_en && ((q.size() < 2) || mpop);
            if (mpop) void'(q.pop_front());
            if (mpush) begin
                q.push_back('{p: mpc, i: mem[mpc]});
                mpc = (mpc + 1) % 512;
                mcnt = mcnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("m_pc", pc, mpc);
            chk("m_count", fetch_count, mcnt);
            chk("m_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
            if (q.size() > 0) begin
                chk("m_out_pc", out_pc, q[0].p);
                chk("m_out_instr", out_instr, q[0].i);
            end else begin
                chk("m_out_pc0", out_pc, 32'd0);
                chk("m_out_instr0", out_instr, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'hC000_0000 | i;
        mem[0] = 32'h0010_8113;
        mem[2] = 32'h0030_2123;

        rst = 1;
        fetch_en = 1;
        out_ready = 1;
        redirect_valid = 0;
        redirect_pc = 0;

        // 1: reset then run
        tick();
        tick();
        chk("rst_pc", pc, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        rst = 0;
        tick();
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_pc0", out_pc, 32'd0);
        chk("t1_instr0", out_instr, 32'h0010_8113);
        tick();
        chk("t1_pc1", out_pc, 32'd1);
        tick();
        chk("t1_pc2", out_pc, 32'd2);
        chk("t1_instr2", out_instr, 32'h0030_2123);
        tick();
        chk("t1_pc3", out_pc, 32'd3);
        chk("t1_cnt4", fetch_count, 32'd4);

        // 2: backpressure
        rst = 1;
        out_ready = 0;
        tick();
        rst = 0;
        tick();
        tick();
        tick();
        chk("t2_pc_hold", pc, 32'd2);
        chk("t2_out_hold", out_pc, 32'd0);
        chk("t2_cnt", fetch_count, 32'd2);
        out_ready = 1;
        tick();
        chk("t2_seq1", out_pc, 32'd1);
        tick();
        chk("t2_seq2", out_pc, 32'd2);
        tick();
        chk("t2_seq3", out_pc, 32'd3);

        // 3: redirect at pc 5
        chk("t3_pc5", pc, 32'd5);
        redirect_valid = 1;
        redirect_pc = 37;
        tick();
        redirect_valid = 0;
        chk("t3_valid0", {31'd0, out_valid}, 32'd0);
        chk("t3_pc37", pc, 32'd37);
        chk("t3_cnt", fetch_count, 32'd5);
        tick();
        chk("t3_out37", out_pc, 32'd37);
        chk("t3_cnt6", fetch_count, 32'd6);

        // 4: wrap and mask
        redirect_valid = 1;
        redirect_pc = 510;
        tick();
        redirect_valid = 0;
        tick();
        chk("t4_510", out_pc, 32'd510);
        tick();
        chk("t4_511", out_pc, 32'd511);
        tick();
        chk("t4_0", out_pc, 32'd0);
        tick();
        chk("t4_1", out_pc, 32'd1);
        redirect_valid = 1;
        redirect_pc = 32'h0000_0205;
        tick();
        redirect_valid = 0;
        chk("t4_mask", pc, 32'd5);

        // 5: full buffer, simultaneous push and pop
        out_ready = 0;
        tick();
        tick();
        tick();
        chk("t5_pc7", pc, 32'd7);
        chk("t5_head5", out_pc, 32'd5);
        out_ready = 1;
        tick();
        chk("t5_pc8", pc, 32'd8);
        chk("t5_head6", out_pc, 32'd6);
        out_ready = 0;
        tick();
        chk("t5_full", pc, 32'd8);

        // 6: reset mid-operation, redirect ignored
        redirect_valid = 1;
        redirect_pc = 38;
        tick();
        redirect_valid = 0;
        tick();
        tick();
        chk("t6_pc40", pc, 32'd40);
        rst = 1;
        redirect_valid = 1;
        redirect_pc = 100;
        tick();
        rst = 0;
        redirect_valid = 0;
        chk("t6_pc0", pc, 32'd0);
        chk("t6_valid0", {31'd0, out_valid}, 32'd0);
        chk("t6_cnt0", fetch_count, 32'd0);

        // fetch_en low: pc holds while buffer drains
        tick();
        tick();
        fetch_en = 0;
        out_ready = 1;
        tick();
        chk("fe_pc", pc, 32'd2);
        tick();
        tick();
        chk("fe_empty", {31'd0, out_valid}, 32'd0);
        redirect_valid = 1;
        redirect_pc = 9;
        tick();
        redirect_valid = 0;
        chk("fe_redir", pc, 32'd9);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch front end that sits directly upstream of the instruction memory.
- Owns the program counter, which is a word index into the instruction array. It drives `pc` to the memory's address input and captures the combinational read data `rd` in the same cycle.
- Buffers {pc, instruction} pairs in a small FIFO and hands them to the decode stage over a valid/ready handshake.
- Supports branch redirect with flush, and stalls fetch when the buffer is full.

Parameters:
- MEM_WORDS, 512: instruction-memory depth in words; PC wraps modulo this value (must be a power of 2).
- DEPTH, 2: fetch-buffer entries (power of 2, >=2).
- RESET_PC, 0: PC value loaded on reset (word index, < MEM_WORDS).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- fetch_en  input  1  allows new fetches when high
- pc  output  32  current fetch address to instruction memory (word index)
- rd  input  32  instruction word from memory, valid combinationally for `pc` in the same cycle
- redirect_valid  input  1  branch/jump taken; flush the buffer and load redirect_pc
- redirect_pc  input  32  redirect target (word index)
- out_valid  output  1  buffer head holds a valid instruction
- out_ready  input  1  decode accepts the head this cycle
- out_instr  output  32  instruction at the buffer head
- out_pc  output  32  PC of out_instr
- fetch_count  output  32  number of instructions pushed since reset, wraps at 2^32

Behaviour:
- Single clock; all state updates on rising clk; rst is sampled synchronously and is active-high.
- Reset values:
  - pc = RESET_PC
  - FIFO empty; out_valid = 0, out_instr = 0, out_pc = 0
  - fetch_count = 0
- rst has priority over every other input. Asserting rst mid-stream discards all buffered entries; fetch restarts at RESET_PC.
- Internal signals:
  - pop = out_valid & out_ready
  - can_push = fetch_en & (count < DEPTH | pop)
- Normal cycle (no rst, no redirect):
  - If can_push: write {pc, rd} at the tail, advance pc, increment fetch_count.
  - pc advances as pc_next = (pc + 1) mod MEM_WORDS, so MEM_WORDS-1 wraps to 0.
  - If pop: advance the head.
  - Push and pop in the same cycle are legal. When full, this keeps count at DEPTH with no bubble.
- Latency: the instruction at address A is visible on out_* one cycle after the cycle pc == A is pushed. With out_ready held high, throughput is one instruction per cycle.
- Stall: when count == DEPTH and no pop, no push occurs. pc, fetch_count and FIFO contents hold.
- fetch_en low: no push and pc holds; pops continue draining the buffer.
- Empty: out_valid = 0; out_instr and out_pc read 0. out_ready is ignored when empty.
- Outputs are driven from FIFO storage (registered), never combinationally from rd.
- Redirect (redirect_valid = 1, rst = 0):
  - Next-cycle pc = redirect_pc mod MEM_WORDS; upper bits are zeroed.
  - FIFO cleared (count = 0, head = tail = 0); out_valid = 0 the following cycle.
  - No push this cycle: the word at the old pc is dropped and fetch_count is unchanged.
  - A pop coinciding with a redirect counts as accepted by decode. The block takes no further action for it.
  - Redirect overrides push, stall and fetch_en. A redirect while fetch_en = 0 still loads pc.
- FIFO pointers are log2(DEPTH)-bit with natural wrap; count is log2(DEPTH)+1 bits.
- No X propagation: rd is stored as presented; unwritten memory words pass through unchanged.

Test Plan:
1. Reset then run: rst for 2 cycles, fetch_en = 1, out_ready = 1; memory holds words 0x00108113 at 0 and 0x00302123 at 2.
   - Required: cycle 1 after reset, out_valid = 1, out_pc = 0, out_instr = 0x00108113.
   - Required: out_pc increments 0,1,2,3 on consecutive cycles; fetch_count = 4 after 4 cycles.
2. Backpressure: out_ready = 0 from start.
   - Required: after 2 pushes count = DEPTH = 2; pc holds at 2 and out_pc holds at 0.
   - Then out_ready = 1: out_pc sequence 0,1,2,3 with no gap or duplicate.
3. Redirect: while streaming with pc = 5, pulse redirect_valid with redirect_pc = 37.
   - Required: next cycle out_valid = 0 and pc = 37.
   - Required: the following cycle out_pc = 37; fetch_count does not count the dropped word at 5.
4. Wrap and mask:
   - redirect_pc = 510: required out_pc sequence 510, 511, 0, 1.
   - redirect_pc = 0x00000205: required pc = 5.
5. Simultaneous full push/pop: fill the buffer (count = 2), then out_ready = 1 for one cycle.
   - Required: the head pops and a new entry pushes in the same cycle; count stays 2; pc advances by 1.
6. Reset mid-operation: assert rst with count = 2 and pc = 40.
   - Required: next cycle pc = 0, out_valid = 0, fetch_count = 0.
   - Redirect asserted together with rst is ignored.
